// File: rtl/systolic_seq_ctrl.sv
// rtl/systolic_seq_ctrl.sv - pass sequencer for the systolic array (clear, feed DIM rows, drain, done)
// Optional SEQ_PERF_CNT_EN adds busy/stall cycle counters.
module systolic_seq_ctrl #(
   parameter int DIM       = 8,
   parameter int DRAIN_CYC = 22,
   localparam int CW = $clog2(((DIM > DRAIN_CYC) ? DIM : DRAIN_CYC) + 1),
   localparam int RW = (DIM > 1) ? $clog2(DIM) : 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic          abort,
   input  logic          stall,
   output logic          mem_en,
   output logic          feed_vld,
   output logic [RW-1:0] row_idx,
   output logic          mac_clr,
   output logic          mac_en,
   output logic          busy,
   output logic          done
`ifdef SEQ_PERF_CNT_EN
   ,
   output logic [31:0]   perf_busy_cyc,
   output logic [31:0]   perf_stall_cyc
`endif
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLEAR,
      S_FEED,
      S_DRAIN,
      S_DONE
   } state_t;

   state_t        r_state;
   state_t        w_state_nxt;
   logic [CW-1:0] r_cnt;
   logic [CW-1:0] w_cnt_nxt;
   logic          w_hold;

   logic          r_mem_en;
   logic          r_feed_vld;
   logic [RW-1:0] r_row_idx;
   logic          r_mac_clr;
   logic          r_mac_en;
   logic          r_busy;
   logic          r_done;

   logic          w_mem_en;
   logic          w_feed_vld;
   logic [RW-1:0] w_row_idx;
   logic          w_mac_clr;
   logic          w_mac_en;
   logic          w_busy;
   logic          w_done;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   // Outputs are decoded from the next state so they line up with the state they describe.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_hold      = 1'b0;
      if (abort && (r_state != S_IDLE)) begin
         w_state_nxt = S_IDLE;
         w_cnt_nxt   = '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  w_state_nxt = S_CLEAR;
                  w_cnt_nxt   = '0;
               end
            end
            S_CLEAR: begin
               w_state_nxt = S_FEED;
               w_cnt_nxt   = '0;
            end
            S_FEED: begin
               if (stall) begin
                  w_hold = 1'b1;
               end else if (r_cnt == CW'(DIM - 1)) begin
                  w_state_nxt = S_DRAIN;
                  w_cnt_nxt   = '0;
               end else begin
                  w_cnt_nxt = r_cnt + 1'b1;
               end
            end
            S_DRAIN: begin
               if (stall) begin
                  w_hold = 1'b1;
               end else if (r_cnt == CW'(DRAIN_CYC - 1)) begin
                  w_state_nxt = S_DONE;
                  w_cnt_nxt   = '0;
               end else begin
                  w_cnt_nxt = r_cnt + 1'b1;
               end
            end
            S_DONE: begin
               w_state_nxt = start ? S_CLEAR : S_IDLE;
               w_cnt_nxt   = '0;
            end
            default: begin
               w_state_nxt = S_IDLE;
               w_cnt_nxt   = '0;
            end
         endcase
      end
   end

   always_comb begin
      w_mac_clr  = (w_state_nxt == S_CLEAR);
      w_feed_vld = (w_state_nxt == S_FEED);
      w_mem_en   = ((w_state_nxt == S_FEED) || (w_state_nxt == S_DRAIN)) && !w_hold;
      w_mac_en   = w_mem_en;
      w_busy     = (w_state_nxt == S_CLEAR) || (w_state_nxt == S_FEED) ||
                   (w_state_nxt == S_DRAIN);
      w_done     = (w_state_nxt == S_DONE);
      w_row_idx  = (w_state_nxt == S_FEED) ? w_cnt_nxt[RW-1:0] : '0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_mem_en   <= 1'b0;
         r_feed_vld <= 1'b0;
         r_row_idx  <= '0;
         r_mac_clr  <= 1'b0;
         r_mac_en   <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
      end else begin
         r_mem_en   <= w_mem_en;
         r_feed_vld <= w_feed_vld;
         r_row_idx  <= w_row_idx;
         r_mac_clr  <= w_mac_clr;
         r_mac_en   <= w_mac_en;
         r_busy     <= w_busy;
         r_done     <= w_done;
      end
   end

   assign mem_en   = r_mem_en;
   assign feed_vld = r_feed_vld;
   assign row_idx  = r_row_idx;
   assign mac_clr  = r_mac_clr;
   assign mac_en   = r_mac_en;
   assign busy     = r_busy;
   assign done     = r_done;

`ifdef SEQ_PERF_CNT_EN
   logic [31:0] r_perf_busy;
   logic [31:0] r_perf_stall;

   // r_busy reflects the cycle now ending, so each busy cycle is counted at its closing edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_perf_busy  <= '0;
         r_perf_stall <= '0;
      end else if (w_state_nxt == S_CLEAR && r_state != S_CLEAR) begin
         r_perf_busy  <= '0;
         r_perf_stall <= '0;
      end else begin
         if (r_busy && (r_perf_busy != 32'hFFFF_FFFF))
            r_perf_busy <= r_perf_busy + 32'd1;
         if (stall && ((r_state == S_FEED) || (r_state == S_DRAIN)) &&
             (r_perf_stall != 32'hFFFF_FFFF))
            r_perf_stall <= r_perf_stall + 32'd1;
      end
   end

   assign perf_busy_cyc  = r_perf_busy;
   assign perf_stall_cyc = r_perf_stall;
`endif

endmodule

// File: tb/tb_systolic_seq_ctrl.sv
// tb/tb_systolic_seq_ctrl.sv - directed self-checking bench for systolic_seq_ctrl
// Build with SEQ_PERF_CNT_EN to also check the performance counters.
module tb_systolic_seq_ctrl;

   logic       clk;
   logic       rst_n;
   logic       start;
   logic       abort;
   logic       stall;
   logic       mem_en;
   logic       feed_vld;
   logic [2:0] row_idx;
   logic       mac_clr;
   logic       mac_en;
   logic       busy;
   logic       done;
`ifdef SEQ_PERF_CNT_EN
   logic [31:0] perf_busy_cyc;
   logic [31:0] perf_stall_cyc;
`endif

   int n_checks = 0;
   int n_errors = 0;

   systolic_seq_ctrl dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .abort    (abort),
      .stall    (stall),
      .mem_en   (mem_en),
      .feed_vld (feed_vld),
      .row_idx  (row_idx),
      .mac_clr  (mac_clr),
      .mac_en   (mac_en),
      .busy     (busy),
      .done     (done)
`ifdef SEQ_PERF_CNT_EN
      ,
      .perf_busy_cyc  (perf_busy_cyc),
      .perf_stall_cyc (perf_stall_cyc)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   function automatic logic [8:0] outs();
      return {mem_en, feed_vld, row_idx, mac_clr, mac_en, busy, done};
   endfunction

   // Expected {mem_en, feed_vld, row_idx, mac_clr, mac_en, busy, done} for cycle c of an unstalled pass.
   function automatic logic [8:0] exp_vec(input int c);
      logic [2:0] r;
      if (c == 1) return 9'b0_0_000_1_0_1_0;
      if (c >= 2 && c <= 9) begin
         r = 3'(c - 2);
         return {1'b1, 1'b1, r, 1'b0, 1'b1, 1'b1, 1'b0};
      end
      if (c >= 10 && c <= 31) return 9'b1_0_000_0_1_1_0;
      if (c == 32) return 9'b0_0_000_0_0_0_1;
      return 9'b0;
   endfunction

   initial begin
      rst_n = 1'b0;
      start = 1'b0;
      abort = 1'b0;
      stall = 1'b0;
      tick;
      check("reset_outs", 32'(outs()), 32'h0);
`ifdef SEQ_PERF_CNT_EN
      check("reset_perf_busy", perf_busy_cyc, 32'd0);
      check("reset_perf_stall", perf_stall_cyc, 32'd0);
`endif
      tick;
      rst_n = 1'b1;
      tick;
      check("idle_outs", 32'(outs()), 32'h0);

      // Nominal pass.
      start = 1'b1;
      for (int c = 1; c <= 34; c++) begin
         tick;
         start = 1'b0;
         check($sformatf("nom_c%0d", c), 32'(outs()), 32'(exp_vec(c)));
      end

      // Three-cycle stall at row 4.
      start = 1'b1;
      for (int c = 1; c <= 36; c++) begin
         tick;
         start = 1'b0;
         if (c >= 7 && c <= 9)
            check($sformatf("stall_c%0d", c), 32'(outs()), 32'(9'b0_1_100_0_0_1_0));
         else if (c <= 6)
            check($sformatf("stall_c%0d", c), 32'(outs()), 32'(exp_vec(c)));
         else
            check($sformatf("stall_c%0d", c), 32'(outs()), 32'(exp_vec(c - 3)));
`ifdef SEQ_PERF_CNT_EN
         if (c == 35) begin
            check("perf_busy_stall", perf_busy_cyc, 32'd34);
            check("perf_stall_stall", perf_stall_cyc, 32'd3);
         end
`endif
         stall = (c >= 6 && c <= 8);
      end

      // Abort during DRAIN at cycle 15, then a full replay.
      start = 1'b1;
      for (int c = 1; c <= 34; c++) begin
         tick;
         start = 1'b0;
`ifdef SEQ_PERF_CNT_EN
         if (c == 1) begin
            check("perf_busy_clr", perf_busy_cyc, 32'd0);
            check("perf_stall_clr", perf_stall_cyc, 32'd0);
         end
         if (c == 20) check("perf_busy_abort", perf_busy_cyc, 32'd15);
`endif
         check($sformatf("abort_c%0d", c), 32'(outs()), (c <= 15) ? 32'(exp_vec(c)) : 32'h0);
         abort = (c == 15);
      end
      start = 1'b1;
      for (int c = 1; c <= 33; c++) begin
         tick;
         start = 1'b0;
         check($sformatf("replay_c%0d", c), 32'(outs()), 32'(exp_vec(c)));
      end

      // start held high: back-to-back passes.
      start = 1'b1;
      for (int c = 1; c <= 97; c++) begin
         tick;
         check($sformatf("b2b_c%0d", c), 32'(outs()), 32'(exp_vec(((c - 1) % 32) + 1)));
      end
      start = 1'b0;
      abort = 1'b1;
      tick;
      abort = 1'b0;
      check("b2b_abort_idle", 32'(outs()), 32'h0);

      // Asynchronous reset mid-FEED at row 5.
      start = 1'b1;
      for (int c = 1; c <= 7; c++) begin
         tick;
         start = 1'b0;
         check($sformatf("arst_c%0d", c), 32'(outs()), 32'(exp_vec(c)));
      end
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_immediate", 32'(outs()), 32'h0);
      tick;
      tick;
      rst_n = 1'b1;
      for (int c = 1; c <= 3; c++) begin
         tick;
         check($sformatf("arst_idle_%0d", c), 32'(outs()), 32'h0);
      end
      start = 1'b1;
      for (int c = 1; c <= 3; c++) begin
         tick;
         start = 1'b0;
         check($sformatf("arst_restart_c%0d", c), 32'(outs()), 32'(exp_vec(c)));
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/systolic_seq_ctrl.md
Name: systolic_seq_ctrl

Overview:
Sequencer for one matrix-multiply pass through the systolic array datapath: the A/B skew memories (per-row FIFOs, row i depth 8+i) and the MAC array.
- Accepts a start pulse, clears the accumulators, feeds DIM operand rows, then drains until the last skewed product has passed through the array, then pulses done.
- Drives the shared `en` of memA/memB, the tile row index for operand fetch, and the MAC clear/enable controls.

Parameters:
DIM, 8, array dimension; number of operand rows fed per pass; >=1.
DRAIN_CYC, 22, cycles after the last fed row until results are final; default = deepest skew FIFO (8+DIM-1) + DIM-1 array hops; >=1.
CW, $clog2(((DIM>DRAIN_CYC)?DIM:DRAIN_CYC)+1), local counter width; not overridable.

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  begin a pass; sampled only in IDLE or DONE
abort  in  1  synchronous cancel of the current pass
stall  in  1  freeze the sequence, e.g. operand source not ready
mem_en  out  1  enable to memA/memB skew FIFOs
feed_vld  out  1  operand row presented this cycle is real data; 0 means feed zeros
row_idx  out  $clog2(DIM) (min 1)  tile row to present to Bin/Ain
mac_clr  out  1  clear all PE accumulators
mac_en  out  1  PE accumulate enable
busy  out  1  pass in progress
done  out  1  one-cycle pass-complete pulse

Behaviour:
- Moore FSM. All outputs are registered and decoded from state.
- Reset (async, rst_n=0): state IDLE, counter 0, all outputs 0.
- States:
  - IDLE: outputs 0. start=1 -> CLEAR.
  - CLEAR: 1 cycle. mac_clr=1, busy=1, all other outputs 0. -> FEED.
  - FEED: DIM cycles. mem_en=1, feed_vld=1, mac_en=1, busy=1. row_idx=0..DIM-1, incrementing once per non-stalled cycle. After row DIM-1 -> DRAIN with counter reset.
  - DRAIN: DRAIN_CYC cycles. mem_en=1, mac_en=1, busy=1, feed_vld=0, row_idx=0. -> DONE.
  - DONE: 1 cycle. done=1, busy=0. If start=1 -> CLEAR (back-to-back pass), else -> IDLE.
- start in CLEAR/FEED/DRAIN is ignored, with no queueing.
- stall=1 in FEED or DRAIN:
  - state, counter and row_idx hold; mem_en=0 and mac_en=0 that cycle; feed_vld and busy unchanged.
  - stall is ignored in IDLE, CLEAR and DONE.
- abort=1 in any state except IDLE: -> IDLE next cycle, all outputs 0, no done pulse.
  - Priority is abort > stall > start.
- Latency with no stalls, start sampled at edge E0:
  - CLEAR cycle 1.
  - FEED cycles 2..DIM+1.
  - DRAIN cycles DIM+2..DIM+DRAIN_CYC+1.
  - done in cycle DIM+DRAIN_CYC+2. Default: 32.
- Each stalled cycle extends completion by exactly one cycle.
- row_idx wraps never: the FEED exit is taken on the counter equal to DIM-1.
- Counter compares use CW bits, with no overflow at parameter maxima.

Optional Feature:
Macro SEQ_PERF_CNT_EN.
- Defined: adds output ports perf_busy_cyc[31:0] and perf_stall_cyc[31:0].
  - perf_busy_cyc increments every cycle busy=1.
  - perf_stall_cyc increments every cycle stall=1 while in FEED or DRAIN.
  - Both counters clear on rst_n and on entry to CLEAR, saturate at 32'hFFFFFFFF, and hold their values after done/abort.
- Undefined: ports and logic absent; the block is otherwise identical.

Test Plan:
- Defaults, reset, single start pulse, no stall -> mac_clr high cycle 1; feed_vld/mem_en high cycles 2-9 with row_idx 0..7; mem_en high, feed_vld low cycles 10-31; done=1 only cycle 32; busy high cycles 1-31.
- Stall held 3 cycles starting at FEED row_idx=4 -> row_idx stays 4, mem_en=0 for those 3 cycles; done at cycle 35.
- Abort asserted during DRAIN at cycle 15 -> cycle 16 IDLE, all outputs 0, no done; a later start replays a full 32-cycle pass.
- start held high continuously -> passes run back-to-back; DONE goes directly to CLEAR, done pulses at cycles 32, 64, 96; mid-pass start has no effect.
- rst_n dropped asynchronously mid-FEED (row_idx=5) -> outputs 0 immediately, no clock needed; after release, IDLE until start.
- SEQ_PERF_CNT_EN defined, 3-cycle stall as above -> perf_busy_cyc=34, perf_stall_cyc=3 after done; both clear on the next start.
